stack_prog_sequencer: RTL and testbench

//  Upstream instruction feeder for the stack calculator core. Holds a small

---
 rtl/stack_prog_sequencer.sv | 146 ++++++++++++++
 tb/tb_stack_prog_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/stack_prog_sequencer.sv
// Program sequencer for the stack calculator core.
// A host loads (op, operand) words into a small program memory. On start the
// core is cleared, then the instructions are issued one at a time, each one
// followed by a check cycle. The run stops at the first instruction the core
// rejects, or after the last one.
module stack_prog_sequencer #(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [3:0]    prog_op,
  input  logic [W-1:0]  prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  output logic          core_rst,
  output logic [3:0]    core_op,
  output logic [W-1:0]  core_in,
  output logic          core_apply,
  input  logic [W-1:0]  core_head,
  input  logic          core_empty,
  input  logic          core_valid,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [W-1:0]  result,
  output logic          res_empty,
  output logic [AW-1:0] err_pc
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_ISSUE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  // Program store; deliberately not touched by rst so a program survives it.
  logic [3:0]   mem_op_q   [DEPTH];
  logic [W-1:0] mem_data_q [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [W-1:0]  result_q, result_d;
  logic          res_empty_q, res_empty_d;
  logic [AW-1:0] err_pc_q, err_pc_d;
  logic          mem_we;
  logic          run_active;

  assign run_active = (state_q == S_CLR) || (state_q == S_ISSUE) ||
                      (state_q == S_CHECK);
  // The host may only rewrite the program between runs.
  assign mem_we = prog_we && !run_active;

  // Program memory write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_op_q[prog_addr]   <= prog_op;
      mem_data_q[prog_addr] <= prog_data;
    end
  end

  // State and run bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      len_q       <= '0;
      result_q    <= '0;
      res_empty_q <= 1'b1;
      err_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      len_q       <= len_d;
      result_q    <= result_d;
      res_empty_q <= res_empty_d;
      err_pc_q    <= err_pc_d;
    end
  end

  // Next state: clear, then ISSUE/CHECK pairs until the core objects or the
  // program runs out.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    len_d       = len_q;
    result_d    = result_q;
    res_empty_d = res_empty_q;
    err_pc_d    = err_pc_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_CLR;
          pc_d    = '0;
          len_d   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
        end
      end
      S_CLR: begin
        if (len_q != '0) begin
          state_d = S_ISSUE;
        end else begin
          state_d     = S_DONE;
          result_d    = '0;
          res_empty_d = 1'b1;
        end
      end
      // The core latches the instruction on the edge that leaves ISSUE, so
      // its status is only meaningful in CHECK.
      S_ISSUE: state_d = S_CHECK;
      S_CHECK: begin
        if (!core_valid) begin
          state_d  = S_ERROR;
          err_pc_d = pc_q;
        end else if ({1'b0, pc_q} == len_q - (AW+1)'(1)) begin
          state_d     = S_DONE;
          result_d    = core_head;
          res_empty_d = core_empty;
        end else begin
          pc_d    = pc_q + AW'(1);
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state; the instruction port always
  // shows the word at pc.
  always_comb begin
    core_rst   = rst || (state_q == S_CLR);
    core_apply = (state_q == S_ISSUE);
    core_op    = mem_op_q[pc_q];
    core_in    = mem_data_q[pc_q];
    busy       = run_active;
    done       = (state_q == S_DONE);
    error      = (state_q == S_ERROR);
    result     = result_q;
    res_empty  = res_empty_q;
    err_pc     = err_pc_q;
  end

endmodule

// File: tb/tb_stack_prog_sequencer.sv
// Bench for stack_prog_sequencer: a small stack core responder drives the
// core-side inputs, and every run is predicted from a queue-based model of
// the program's meaning (result or first rejected instruction, plus timing).
module tb_stack_prog_sequencer;
  logic        clk = 0;
  logic        rst = 1;
  logic        prog_we = 0;
  logic [3:0]  prog_addr = 0;
  logic [3:0]  prog_op = 0;
  logic [15:0] prog_data = 0;
  logic [4:0]  prog_len = 0;
  logic        start = 0;
  logic        core_rst, core_apply, core_empty, core_valid;
  logic [3:0]  core_op;
  logic [15:0] core_in, core_head;
  logic        busy, done, error, res_empty;
  logic [15:0] result;
  logic [3:0]  err_pc;

  int n_chk = 0, n_pass = 0;
  int apply_cnt = 0, crst_cnt = 0;
  int sh_op [16];
  int sh_data [16];

  stack_prog_sequencer dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_op(prog_op), .prog_data(prog_data), .prog_len(prog_len),
    .start(start), .core_rst(core_rst), .core_op(core_op), .core_in(core_in),
    .core_apply(core_apply), .core_head(core_head), .core_empty(core_empty),
    .core_valid(core_valid), .busy(busy), .done(done), .error(error),
    .result(result), .res_empty(res_empty), .err_pc(err_pc)
  );

  always #5 clk = ~clk;

  // Stack core responder: depth 8; 0 nop, 1 pop, 2 add, 3 sub, 7 push,
  // anything else invalid. Invalid status is sticky until core_rst.
  logic [15:0] stk [8];
  int          sp = 0;
  logic        cvalid = 1'b1;
  always @(posedge clk) begin
    logic [15:0] t [8];
    logic [15:0] a, b;
    int          s;
    logic        v;
    t = stk; s = sp; v = cvalid;
    if (core_rst) begin
      s = 0; v = 1'b1;
    end else if (core_apply && v) begin
      case (core_op)
        4'd0: ;
        4'd7: if (s == 8) v = 1'b0; else begin t[s] = core_in; s++; end
        4'd1: if (s < 1) v = 1'b0; else s--;
        4'd2, 4'd3: begin
          if (s < 2) v = 1'b0;
          else begin
            b = t[s-1]; a = t[s-2]; s -= 2;
            t[s] = (core_op == 4'd2) ? a + b : a - b; s++;
          end
        end
        default: v = 1'b0;
      endcase
    end
    stk <= t; sp <= s; cvalid <= v;
  end
  assign core_head  = (sp > 0) ? stk[sp-1] : 16'h0;
  assign core_empty = (sp == 0);
  assign core_valid = cvalid;

  always @(negedge clk) begin
    if (core_apply) apply_cnt++;
    if (core_rst && !rst) crst_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Program meaning: walk the instructions over a queue stack.
  function automatic void model(input int n, output bit err, output int idx,
                                output int res, output bit emp);
    logic [15:0] q[$];
    logic [15:0] a, b;
    err = 0; idx = 0;
    for (int i = 0; i < n && !err; i++) begin
      case (sh_op[i])
        0: ;
        7: if (q.size() == 8) err = 1; else q.push_back(16'(sh_data[i]));
        1: if (q.size() < 1) err = 1; else void'(q.pop_back());
        2, 3: if (q.size() < 2) err = 1;
              else begin
                b = q.pop_back(); a = q.pop_back();
                q.push_back(sh_op[i] == 2 ? a + b : a - b);
              end
        default: err = 1;
      endcase
      if (err) idx = i;
    end
    res = (q.size() > 0) ? int'(q[q.size()-1]) : 0;
    emp = (q.size() == 0);
  endfunction

  task automatic wr(input int a, input int op, input int d);
    @(negedge clk);
    prog_we = 1; prog_addr = 4'(a); prog_op = 4'(op); prog_data = 16'(d);
    @(negedge clk);
    prog_we = 0;
    sh_op[a] = op; sh_data[a] = d;
  endtask

  // Start a run of len_in instructions and check outcome and timing.
  // scribble: hammer prog_we and start while busy; both must be ignored.
  task automatic run_prog(input int len_in, input bit scribble, input string tag);
    bit err, emp;
    int idx, res, n, cyc, exp_lat;
    n = (len_in > 16) ? 16 : len_in;
    model(n, err, idx, res, emp);
    @(negedge clk);
    prog_len = 5'(len_in); start = 1;
    apply_cnt = 0; crst_cnt = 0;
    @(negedge clk);
    start = 0;
    chk({tag, "_busy"}, busy, 1);
    cyc = 0;
    while (!(done || error) && cyc < 100) begin
      if (scribble) begin
        prog_we = 1; prog_addr = 4'($urandom_range(0, 15));
        prog_op = 4'($urandom); prog_data = 16'($urandom);
        start = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    prog_we = 0; start = 0;
    exp_lat = err ? 2 * idx + 3 : 2 * n + 1;
    chk({tag, "_lat"}, cyc, exp_lat);
    chk({tag, "_done"}, done, !err);
    chk({tag, "_error"}, error, err);
    chk({tag, "_busy0"}, busy, 0);
    chk({tag, "_apply"}, apply_cnt, err ? idx + 1 : n);
    chk({tag, "_crst"}, crst_cnt, 1);
    if (err) chk({tag, "_errpc"}, err_pc, idx);
    else begin
      chk({tag, "_res"}, result, res);
      chk({tag, "_remp"}, res_empty, emp);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_result", result, 0);
    chk("rst_remp", res_empty, 1);
    chk("rst_errpc", err_pc, 0);
    chk("rst_crst", core_rst, 1);
    rst = 0;
    @(negedge clk);

    // 1: two pushes
    wr(0, 7, 5); wr(1, 7, 3);
    run_prog(2, 0, "t1");
    // 2: invalid opcode at pc 1
    wr(0, 7, 1); wr(1, 9, 0);
    run_prog(2, 0, "t2");
    // 3: binary op on a single entry
    wr(1, 2, 0);
    run_prog(2, 0, "t3");
    // 4: empty program, then writes/starts during a run are ignored
    run_prog(0, 0, "t4a");
    wr(0, 7, 4); wr(1, 7, 6); wr(2, 2, 0);
    run_prog(3, 1, "t4b");
    run_prog(3, 0, "t4c");
    // 5: overflow the core, then a short rerun; also a clamped length
    for (int i = 0; i < 16; i++) wr(i, 7, 1);
    run_prog(16, 0, "t5a");
    run_prog(2, 0, "t5b");
    run_prog(31, 0, "t5c");
    // 6: reset during ISSUE of pc 3
    for (int i = 0; i < 6; i++) wr(i, 7, i + 1);
    @(negedge clk);
    prog_len = 6; start = 1;
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    chk("t6_issue", core_apply, 1);
    rst = 1;
    #1 chk("t6_crst", core_rst, 1);
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_error", error, 0);
    rst = 0;
    @(negedge clk);
    chk("t6_idle", busy, 0);
    run_prog(6, 0, "t6r");

    // Random programs
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < 16; i++) begin
        int r, op;
        r = $urandom_range(0, 12);
        op = (r < 6) ? 7 : (r == 6) ? 1 : (r < 9) ? 2 : (r == 9) ? 3 :
             (r == 10) ? 0 : (r == 11) ? 9 : 12;
        wr(i, op, $urandom_range(0, 65535));
      end
      run_prog($urandom_range(0, 20), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
